// File: rtl/bwt_rotation_sort.sv
// -----------------------------------------------------------------------------
// bwt_rotation_sort
//   Forward Burrows-Wheeler transform stage. Captures an N-symbol block, sorts
//   its N cyclic rotations lexicographically with a stable bubble sort over an
//   index array (one compare-and-swap per cycle), then emits the last column L
//   and the primary index, which is the sorted row that holds rotation 0.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        one-cycle request, data_in sampled when idle
//   data_in      input block, data_in[0] is the first symbol
//   busy         high from the cycle after an accepted start through the done cycle
//   done         one-cycle pulse, data_out/primary_idx valid from that cycle on
//   data_out     last column L, data_out[i] = last symbol of sorted row i
//   primary_idx  sorted row holding the unrotated block
// -----------------------------------------------------------------------------
module bwt_rotation_sort #(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     data_in [0:N-1],
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     data_out [0:N-1],
  output logic [IDX_W-1:0] primary_idx
);

  localparam int PASS_W = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [W-1:0]      sym_buf [0:N-1];
  logic [IDX_W-1:0]  idx     [0:N-1];
  logic [IDX_W-1:0]  j;
  logic [PASS_W-1:0] pass;
  logic              swapped;

  logic              start_acc;
  logic [IDX_W-1:0]  j_nx1;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [W-1:0]      sym_a, sym_b;
  logic              decided;
  logic              do_swap;
  logic              pass_end;
  logic              sort_exit;
  logic [IDX_W-1:0]  prim_nx;

  // Rotation offset with an explicit mod-N, so N need not be a power of two.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input int               off);
    return IDX_W'((int'(base) + off) % N);
  endfunction

  // Rotation comparator: scans all N symbol positions, the first differing
  // position decides. Equal rotations never swap, which keeps the sort stable.
  always_comb begin
    j_nx1   = j + 1'b1;
    idx_a   = idx[j];
    idx_b   = idx[j_nx1];
    sym_a   = '0;
    sym_b   = '0;
    decided = 1'b0;
    do_swap = 1'b0;
    for (int k = 0; k < N; k++) begin
      sym_a = sym_buf[wrap_add(idx_a, k)];
      sym_b = sym_buf[wrap_add(idx_b, k)];
      if (!decided && (sym_a != sym_b)) begin
        decided = 1'b1;
        do_swap = (sym_a > sym_b);
      end
    end
    pass_end  = (j == IDX_W'(N - 2));
    // Finish after a clean pass, or once N-1 passes guarantee a sorted array.
    sort_exit = pass_end && (!(swapped || do_swap) || (pass == PASS_W'(N - 2)));
  end

  // Sorted row that holds rotation 0.
  always_comb begin
    prim_nx = '0;
    for (int i = 0; i < N; i++) begin
      if (idx[i] == '0) prim_nx = IDX_W'(i);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_acc) state_nx = LOAD;
      LOAD:    state_nx = SORT;
      SORT:    if (sort_exit) state_nx = EMIT;
      EMIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs. The done cycle is already IDLE in the state register, so it
  // is excluded from accepting a start and still counts as busy.
  always_comb begin
    busy      = (state != IDLE) || done;
    start_acc = start && (state == IDLE) && !done;
  end

  // Block buffer, index array, sort counters and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        sym_buf[i]  <= '0;
        idx[i]      <= '0;
        data_out[i] <= '0;
      end
      j           <= '0;
      pass        <= '0;
      swapped     <= 1'b0;
      primary_idx <= '0;
      done        <= 1'b0;
    end else begin
      done <= (state == EMIT);
      case (state)
        IDLE: begin
          if (start_acc) begin
            for (int i = 0; i < N; i++) begin
              sym_buf[i] <= data_in[i];
              idx[i]     <= IDX_W'(i);
            end
            j       <= '0;
            pass    <= '0;
            swapped <= 1'b0;
          end
        end
        SORT: begin
          if (do_swap) begin
            idx[j]     <= idx_b;
            idx[j_nx1] <= idx_a;
          end
          if (pass_end) begin
            pass    <= pass + 1'b1;
            j       <= '0;
            swapped <= 1'b0;
          end else begin
            j       <= j_nx1;
            swapped <= swapped | do_swap;
          end
        end
        EMIT: begin
          // Last symbol of rotation r is at position r-1 (mod N).
          for (int i = 0; i < N; i++) begin
            data_out[i] <= sym_buf[wrap_add(idx[i], N - 1)];
          end
          primary_idx <= prim_nx;
        end
        default: ;
      endcase
    end
  end

endmodule
